dmem_responder: RTL and testbench

- Word-addressed data-memory target that services load/store requests from the processor's memory-access initiator.
- Uses a valid/ready request channel and a valid/ready response channel.
- Models configurable wait states, so pipelined and multicycle cores can be exercised against realistic memory latency.
- Flags misaligned and out-of-range accesses instead of silently aliasing them.

---
 rtl/dmem_responder_if.sv | 24 ++
 rtl/dmem_responder.sv | 126 ++++++++++++
 tb/tb_dmem_responder.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ---- dmem_responder_if : request/response channels between a load/store initiator and the data memory (rev 1.0) ----
interface dmem_responder_if;
   logic        req_valid;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_ready;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ---- dmem_responder : word-addressed data memory with programmable wait states and error flagging (rev 1.0) ----
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  wire logic       clk,
   input  wire logic       rst,
   dmem_responder_if.slave dmem_if
);
   localparam int unsigned c_IDX_W      = $clog2(DEPTH_WORDS);
   localparam logic [32:0] c_BYTE_LIMIT = 33'(DEPTH_WORDS) << 2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                we_q, we_d;
   logic [31:0]         addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [31:0]         rdata_q, rdata_d;
   logic                err_q, err_d;
   logic [31:0]         mem_q [DEPTH_WORDS];

   logic                acc_go;
   logic                acc_we;
   logic [31:0]         acc_addr;
   logic [31:0]         acc_wdata;
   logic                acc_err;
   logic [c_IDX_W-1:0]  acc_idx;
   logic                mem_we;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      acc_go    = 1'b0;
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;

      case (state_q)
         S_IDLE: begin
            if (dmem_if.req_valid) begin
               we_d    = dmem_if.req_we;
               addr_d  = dmem_if.req_addr;
               wdata_d = dmem_if.req_wdata;
               if (WAIT_CYCLES == 0) begin
                  // zero-wait: the access uses the live request on the accepting edge
                  acc_go    = 1'b1;
                  acc_we    = dmem_if.req_we;
                  acc_addr  = dmem_if.req_addr;
                  acc_wdata = dmem_if.req_wdata;
                  state_d   = S_RESP;
               end else begin
                  cnt_d   = 4'(WAIT_CYCLES);
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               acc_go  = 1'b1;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (dmem_if.resp_ready) begin
               state_d = S_IDLE;
               rdata_d = 32'd0;
               err_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // 33-bit compare so the limit cannot wrap for the largest depths
      acc_err = (acc_addr[1:0] != 2'b00) || ({1'b0, acc_addr} >= c_BYTE_LIMIT);
      acc_idx = acc_addr[c_IDX_W+1:2];
      mem_we  = acc_go && acc_we && !acc_err;
      if (acc_go) begin
         err_d   = acc_err;
         rdata_d = (acc_err || acc_we) ? 32'd0 : mem_q[acc_idx];
      end
   end

   // memory shares the reset-qualified edge so no write can land while reset is held
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         if (mem_we) begin
            mem_q[acc_idx] <= acc_wdata;
         end
      end
   end

   assign dmem_if.req_ready  = (state_q == S_IDLE);
   assign dmem_if.resp_valid = (state_q == S_RESP);
   assign dmem_if.resp_rdata = rdata_q;
   assign dmem_if.resp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ---- tb_dmem_responder : two responders (2 and 0 wait states) on shared stimulus, checked against a timestamp model (rev 1.0) ----
module tb_dmem_responder;
   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        resp_ready = 1'b1;
   int          n_pass = 0;
   int          n_total = 0;

   always #5 clk = ~clk;

   dmem_responder_if b2 ();
   dmem_responder_if b0 ();

   assign b2.req_valid  = req_valid;
   assign b2.req_we     = req_we;
   assign b2.req_addr   = req_addr;
   assign b2.req_wdata  = req_wdata;
   assign b2.resp_ready = resp_ready;
   assign b0.req_valid  = req_valid;
   assign b0.req_we     = req_we;
   assign b0.req_addr   = req_addr;
   assign b0.req_wdata  = req_wdata;
   assign b0.resp_ready = resp_ready;

   dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut2 (.clk(clk), .rst(rst), .dmem_if(b2.slave));
   dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .dmem_if(b0.slave));

   // index 0 = two-wait-state responder, index 1 = zero-wait-state responder
   function automatic int lat_of(input int k);
      return (k == 0) ? 2 : 0;
   endfunction
   function automatic logic f_ready(input int k);
      return (k == 0) ? b2.req_ready : b0.req_ready;
   endfunction
   function automatic logic f_valid(input int k);
      return (k == 0) ? b2.resp_valid : b0.resp_valid;
   endfunction
   function automatic logic [31:0] f_rdata(input int k);
      return (k == 0) ? b2.resp_rdata : b0.resp_rdata;
   endfunction
   function automatic logic f_err(input int k);
      return (k == 0) ? b2.resp_err : b0.resp_err;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // model: a request is pending from its accept edge; the access happens lat edges later
   logic [31:0] m_mem [2][DEPTH];
   bit          m_busy [2];
   bit          m_valid [2];
   bit          m_err [2];
   bit          m_we [2];
   logic [31:0] m_rdata [2];
   logic [31:0] m_addr [2];
   logic [31:0] m_wdata [2];
   int          m_t_acc [2];
   int          cyc = 0;

   function automatic void m_access(input int k);
      bit         bad;
      logic [7:0] idx;
      bad = (m_addr[k][1:0] != 2'b00) || (m_addr[k] >= 32'(4 * DEPTH));
      idx = m_addr[k][9:2];
      m_valid[k] = 1'b1;
      m_err[k]   = bad;
      m_rdata[k] = 32'd0;
      if (!bad) begin
         if (m_we[k]) m_mem[k][idx] = m_wdata[k];
         else         m_rdata[k]    = m_mem[k][idx];
      end
   endfunction

   initial begin
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            for (int k = 0; k < 2; k++) begin
               m_busy[k] = 1'b0; m_valid[k] = 1'b0; m_rdata[k] = 32'd0; m_err[k] = 1'b0;
            end
         end else begin
            cyc++;
            for (int k = 0; k < 2; k++) begin
               if (m_valid[k]) begin
                  if (resp_ready) begin
                     m_valid[k] = 1'b0; m_busy[k] = 1'b0; m_rdata[k] = 32'd0; m_err[k] = 1'b0;
                  end
               end else if (!m_busy[k] && req_valid) begin
                  m_busy[k]  = 1'b1;
                  m_t_acc[k] = cyc;
                  m_we[k]    = req_we;
                  m_addr[k]  = req_addr;
                  m_wdata[k] = req_wdata;
               end
               if (m_busy[k] && !m_valid[k] && cyc == m_t_acc[k] + lat_of(k)) m_access(k);
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("dut%0d req_ready", k),  32'(f_ready(k)), 32'(!m_busy[k]));
            chk($sformatf("dut%0d resp_valid", k), 32'(f_valid(k)), 32'(m_valid[k]));
            chk($sformatf("dut%0d resp_rdata", k), f_rdata(k),      m_rdata[k]);
            chk($sformatf("dut%0d resp_err", k),   32'(f_err(k)),   32'(m_err[k]));
         end
      end
   end

   task automatic wait_ready(input int k);
      int n = 0;
      while (!f_ready(k) && n < 40) begin @(posedge clk); #1; n++; end
      chk("accept wait bound", 32'(n < 40), 32'd1);
   endtask

   task automatic txn(input int k, input logic we, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output int lat);
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; resp_ready = 1'b1;
      wait_ready(k);
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("ready after accept", 32'(f_ready(k)), 32'd0);
      lat = 0;
      while (!f_valid(k) && lat < 40) begin @(posedge clk); #1; lat++; end
      rd = f_rdata(k);
      er = f_err(k);
      @(posedge clk); #1;
      chk("ready after retire", 32'(f_ready(k)), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;
      int          r;

      // reset held with a live request: nothing may move
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'hFFFF_FFFF;
      repeat (3) begin
         @(posedge clk); #1;
         chk("rst req_ready", 32'(b2.req_ready), 32'd1);
         chk("rst resp_valid", 32'(b2.resp_valid), 32'd0);
         chk("rst resp_rdata", b0.resp_rdata, 32'd0);
         chk("rst resp_err", 32'(b0.resp_err), 32'd0);
      end
      req_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < DEPTH; i++)
         txn(0, 1'b1, 32'(i * 4), (i == 8) ? 32'd0 : $urandom, rd, er, lat);

      txn(0, 1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat);
      chk("store latency", 32'(lat), 32'd2);
      chk("store err", 32'(er), 32'd0);
      chk("store rdata", rd, 32'd0);
      txn(0, 1'b0, 32'h10, 32'd0, rd, er, lat);
      chk("load 0x10", rd, 32'hDEADBEEF);

      txn(0, 1'b1, 32'h13, 32'h11111111, rd, er, lat);
      chk("misaligned err", 32'(er), 32'd1);
      chk("misaligned rdata", rd, 32'd0);
      txn(0, 1'b0, 32'h10, 32'd0, rd, er, lat);
      chk("load 0x10 after misaligned", rd, 32'hDEADBEEF);

      txn(0, 1'b0, 32'h400, 32'd0, rd, er, lat);
      chk("oor err", 32'(er), 32'd1);
      chk("oor rdata", rd, 32'd0);
      txn(0, 1'b0, 32'h3FC, 32'd0, rd, er, lat);
      chk("last word err", 32'(er), 32'd0);
      txn(0, 1'b0, 32'h8000_0010, 32'd0, rd, er, lat);
      chk("high bit err", 32'(er), 32'd1);

      // response backpressure while the request side thrashes
      resp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
      wait_ready(0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      for (int i = 0; i < 5; i++) begin
         chk("bp resp_valid", 32'(b2.resp_valid), 32'd1);
         chk("bp resp_rdata", b2.resp_rdata, 32'hDEADBEEF);
         chk("bp req_ready", 32'(b2.req_ready), 32'd0);
         req_valid = 1'($urandom_range(0, 1));
         req_we    = 1'($urandom_range(0, 1));
         req_addr  = $urandom;
         @(posedge clk); #1;
      end
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h3FC; resp_ready = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("bp release valid", 32'(b2.resp_valid), 32'd0);
      chk("bp release ready", 32'(b2.req_ready), 32'd1);
      @(posedge clk); #1;
      chk("bp no extra accept", 32'(b2.req_ready), 32'd1);

      // reset one cycle into the wait: store must vanish
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
      wait_ready(0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("midwait rst ready", 32'(b2.req_ready), 32'd1);
      chk("midwait rst valid", 32'(b2.resp_valid), 32'd0);
      chk("midwait rst rdata", b2.resp_rdata, 32'd0);
      chk("midwait rst err", 32'(b2.resp_err), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      txn(0, 1'b0, 32'h20, 32'd0, rd, er, lat);
      chk("load 0x20 after dropped store", rd, 32'd0);

      txn(1, 1'b1, 32'h20, 32'h12345678, rd, er, lat);
      chk("zero-wait latency", 32'(lat), 32'd0);
      txn(1, 1'b0, 32'h20, 32'd0, rd, er, lat);
      chk("zero-wait load 0x20", rd, 32'h12345678);

      // reset while the zero-wait responder holds a response
      resp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h20;
      wait_ready(1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("zero-wait resp held", 32'(b0.resp_valid), 32'd1);
      rst = 1'b0;
      #1;
      chk("resp rst valid", 32'(b0.resp_valid), 32'd0);
      chk("resp rst rdata", b0.resp_rdata, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1; resp_ready = 1'b1;

      for (int i = 0; i < 3000; i++) begin
         r = int'($urandom_range(0, 9));
         req_valid  = 1'($urandom_range(0, 1));
         req_we     = 1'($urandom_range(0, 1));
         req_wdata  = $urandom;
         resp_ready = ($urandom_range(0, 3) != 0);
         case (r)
            6:       req_addr = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
            7:       req_addr = 32'h400 + {$urandom_range(0, 1023), 2'b00};
            8:       req_addr = 32'h8000_0000 | {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            9:       req_addr = $urandom;
            default: req_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
         endcase
         if ($urandom_range(0, 99) == 0) begin
            #2 rst = 1'b0;
            @(posedge clk); #1;
            rst = 1'b1;
         end else begin
            @(posedge clk); #1;
         end
      end

      req_valid = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
`default_nettype wire
